output_port_credit_scheduler: RTL and testbench

//  Per-output-port scheduler for a 5-port mesh router. Picks one of five input ports (local/N/S/E/W)

---
 rtl/output_port_credit_scheduler.sv | 168 ++++++++++++++++
 tb/tb_output_port_credit_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_credit_scheduler.sv
// Per-output-port wormhole scheduler: round-robin pick among 5 inputs, credit-paced flit transfer.
// Optional stall watchdog enabled by defining NOC_OSCHED_WATCHDOG_EN.
module output_port_credit_scheduler #(
  parameter int packet_size = 32,
  parameter int flit_size   = 4,
  parameter int credit_max  = 8,
  parameter int stall_limit = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] request,
  input  logic [4:0] flit_valid,
  input  logic       credit_return,
  output logic [4:0] grant_vec,
  output logic [2:0] crossbar_control,
  output logic [4:0] flit_pop,
  output logic       write_request,
  output logic [3:0] credits,
  output logic       busy,
  output logic       credit_err,
  output logic       stall_err
);

  localparam int FLITS = packet_size / flit_size;
  localparam int CW    = (FLITS > 1) ? $clog2(FLITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [4:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    credits_q, credits_d;
  logic [2:0]    xbar_q, xbar_d;
  logic          cerr_q, cerr_d;

  logic          win_valid;
  logic [2:0]    win_idx;
  logic [4:0]    win_vec;
  logic [3:0]    cand;
  logic          xfer;
  logic          last;

  // Rotate-by-pointer priority search; the candidate index is already unrotated.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!win_valid && request[cand[2:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[2:0];
      end
    end
    win_vec = 5'b00001 << win_idx;
  end

  assign xfer = (state_q == SEND) && (|(flit_valid & grant_q)) && (credits_q != '0);
  assign last = xfer && (cnt_q == CW'(FLITS - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    xbar_d  = xbar_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = SEND;
          grant_d = win_vec;
          ptr_d   = (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
          cnt_d   = '0;
          xbar_d  = win_idx;
        end
      end
      SEND: begin
        if (xfer) cnt_d = cnt_q + CW'(1);
        // Zero-bubble handover: next winner loads on the same edge as the last flit.
        if (last) begin
          cnt_d = '0;
          if (win_valid) begin
            grant_d = win_vec;
            ptr_d   = (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
            xbar_d  = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            xbar_d  = 3'd5;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    cerr_d    = cerr_q;
    if (credit_return && credits_q == 4'(credit_max)) cerr_d = 1'b1;
    unique case ({xfer, credit_return})
      2'b10:   credits_d = credits_q - 4'd1;
      2'b01:   if (credits_q != 4'(credit_max)) credits_d = credits_q + 4'd1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      credits_q <= 4'(credit_max);
      xbar_q    <= 3'd5;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      xbar_q    <= xbar_d;
      cerr_q    <= cerr_d;
    end
  end

`ifdef NOC_OSCHED_WATCHDOG_EN
  localparam int SW = $clog2(stall_limit + 1);

  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          serr_q, serr_d;

  // Counter saturates at the limit; the flag is sticky and never releases the grant.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    serr_d      = serr_q;
    if (state_q != SEND || xfer) stall_cnt_d = '0;
    else if (stall_cnt_q != SW'(stall_limit)) stall_cnt_d = stall_cnt_q + SW'(1);
    if (stall_cnt_d == SW'(stall_limit)) serr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      serr_q      <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      serr_q      <= serr_d;
    end
  end

  assign stall_err = serr_q;
`else
  assign stall_err = 1'b0;
`endif

  assign grant_vec        = grant_q;
  assign crossbar_control = xbar_q;
  assign flit_pop         = xfer ? grant_q : '0;
  assign write_request    = xfer;
  assign credits          = credits_q;
  assign busy             = (state_q == SEND);
  assign credit_err       = cerr_q;

endmodule

// File: tb/tb_output_port_credit_scheduler.sv
// Bench for output_port_credit_scheduler: vector table, directed corner sequences, random vs. model.
module tb_output_port_credit_scheduler;

  localparam int FLITS = 8;
  localparam int CMAX  = 8;
  localparam int STALL = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] request, flit_valid;
  logic       credit_return;
  logic [4:0] grant_vec, flit_pop;
  logic [2:0] crossbar_control;
  logic       write_request, busy, credit_err, stall_err;
  logic [3:0] credits;

  int vectors = 0;
  int miscompares = 0;

  output_port_credit_scheduler #(
    .packet_size(32), .flit_size(4), .credit_max(CMAX), .stall_limit(STALL)
  ) dut (
    .clk(clk), .reset(reset), .request(request), .flit_valid(flit_valid),
    .credit_return(credit_return), .grant_vec(grant_vec), .crossbar_control(crossbar_control),
    .flit_pop(flit_pop), .write_request(write_request), .credits(credits), .busy(busy),
    .credit_err(credit_err), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // Reference model state: which port owns the output, how far into the packet, credit balance.
  bit m_busy; int m_port, m_cnt, m_ptr, m_cred, m_stall; bit m_cerr, m_serr;

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_cnt = 0; m_ptr = 0; m_cred = CMAX;
    m_stall = 0; m_cerr = 0; m_serr = 0;
  endtask

  function automatic int pick(input logic [4:0] req);
    for (int k = 0; k < 5; k++) if (req[(m_ptr + k) % 5]) return (m_ptr + k) % 5;
    return -1;
  endfunction

  function automatic logic [20:0] model_exp(input logic [4:0] fv);
    logic [4:0] g; logic x;
    g = m_busy ? (5'(1) << m_port) : 5'b0;
    x = m_busy && fv[m_port] && (m_cred > 0);
    return {g, m_busy ? 3'(m_port) : 3'd5, x ? g : 5'b0, x, 4'(m_cred), m_busy, m_cerr, m_serr};
  endfunction

  task automatic model_step(input logic [4:0] req, input logic [4:0] fv, input logic cr);
    int w; bit x;
    x = m_busy && fv[m_port] && (m_cred > 0);
    if (m_busy && !x) m_stall++; else m_stall = 0;
`ifdef NOC_OSCHED_WATCHDOG_EN
    if (m_stall >= STALL) m_serr = 1;
`endif
    if (cr && m_cred == CMAX) m_cerr = 1;
    m_cred = m_cred - int'(x) + int'(cr);
    if (m_cred > CMAX) m_cred = CMAX;
    w = pick(req);
    if (!m_busy || (x && m_cnt == FLITS - 1)) begin
      if (w >= 0) begin
        m_busy = 1; m_port = w; m_cnt = 0; m_ptr = (w + 1) % 5;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end else if (x) m_cnt++;
  endtask

  function automatic logic [20:0] dut_bundle();
    return {grant_vec, crossbar_control, flit_pop, write_request, credits, busy, credit_err, stall_err};
  endfunction

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got grant=%b xbar=%0d pop=%b wr=%b cred=%0d busy=%b cerr=%b serr=%b, want grant=%b xbar=%0d pop=%b wr=%b cred=%0d busy=%b cerr=%b serr=%b",
        tag, got[20:16], got[15:13], got[12:8], got[7], got[6:3], got[2], got[1], got[0],
        exp[20:16], exp[15:13], exp[12:8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_v(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check vs model, advance model, return after the next negedge.
  task automatic cyc(input logic [4:0] req, input logic [4:0] fv, input logic cr,
                     input string tag, output logic [20:0] got);
    request = req; flit_valid = fv; credit_return = cr;
    #1;
    got = dut_bundle();
    chk(tag, got, model_exp(fv));
    model_step(req, fv, cr);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [4:0] req; logic [4:0] fv; logic cr;
    logic [4:0] grant; logic [2:0] xbar; logic wr; logic [3:0] cred; logic bsy;
  } vec_t;

  vec_t tbl[13];
  logic [20:0] got;
  int order[$];
  int idle_cycles;
  logic [4:0] prev_g;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Single-port packet from reset, then credit returns while idle.
    tbl[0]  = '{5'b00100, 5'b11111, 1'b0, 5'b00000, 3'd5, 1'b0, 4'd8, 1'b0};
    tbl[1]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd8, 1'b1};
    tbl[2]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd7, 1'b1};
    tbl[3]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd6, 1'b1};
    tbl[4]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd5, 1'b1};
    tbl[5]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd4, 1'b1};
    tbl[6]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd3, 1'b1};
    tbl[7]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd2, 1'b1};
    tbl[8]  = '{5'b00000, 5'b11111, 1'b0, 5'b00100, 3'd2, 1'b1, 4'd1, 1'b1};
    tbl[9]  = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 3'd5, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd5, 1'b0, 4'd1, 1'b0};
    tbl[11] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd5, 1'b0, 4'd2, 1'b0};
    tbl[12] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd5, 1'b0, 4'd3, 1'b0};

    reset = 1'b0; request = '0; flit_valid = '0; credit_return = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", dut_bundle(), {5'b0, 3'd5, 5'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      request = tbl[i].req; flit_valid = tbl[i].fv; credit_return = tbl[i].cr;
      #1;
      chk($sformatf("table[%0d]", i), dut_bundle(),
          {tbl[i].grant, tbl[i].xbar, tbl[i].wr ? tbl[i].grant : 5'b0, tbl[i].wr, tbl[i].cred,
           tbl[i].bsy, 1'b0, 1'b0});
      model_step(tbl[i].req, tbl[i].fv, tbl[i].cr);
      @(posedge clk);
      @(negedge clk);
    end

    // Credit starvation mid-packet: 3 credits, port N, stall, then resume from flit 3.
    cyc(5'b00010, 5'h1F, 1'b0, "starve_load", got);
    for (int i = 1; i <= 3; i++) cyc(5'b0, 5'h1F, 1'b0, "starve_pre", got);
    for (int i = 4; i <= 8; i++) begin
      cyc(5'b0, 5'h1F, 1'b0, "starve_hold", got);
      chk_v("starve_wr0", int'(got[7]), 0);
    end
    cyc(5'b0, 5'h1F, 1'b1, "starve_ret", got);
    chk_v("starve_ret_wr0", int'(got[7]), 0);
    cyc(5'b0, 5'h1F, 1'b1, "starve_resume", got);
    chk_v("resume_wr1", int'(got[7]), 1);
    for (int i = 11; i <= 13; i++) cyc(5'b0, 5'h1F, 1'b1, "starve_tail", got);
    cyc(5'b0, 5'h1F, 1'b1, "starve_last", got);
    chk_v("last_flit_busy", int'(got[2]), 1);
    cyc(5'b0, 5'h00, 1'b1, "starve_idle", got);
    chk_v("after_last_idle", int'(got[2]), 0);
    cyc(5'b0, 5'h00, 1'b1, "refill", got);

    // Simultaneous transfer and return at 3 credits, then overflow return at max.
    cyc(5'b10000, 5'h1F, 1'b0, "w_load", got);
    cyc(5'b0, 5'h1F, 1'b1, "xfer_and_ret", got);
    chk_v("xfer_and_ret_wr", int'(got[7]), 1);
    chk_v("credits_hold_3", int'(credits), 3);
    chk_v("credit_err_clear", int'(credit_err), 0);
    for (int i = 0; i < 19; i++) cyc(5'b0, 5'h1F, 1'b1, "overflow_run", got);
    chk_v("credits_sat_8", int'(credits), 8);
    chk_v("credit_err_set", int'(credit_err), 1);

    // All ports requesting: round-robin order with no idle cycle between packets.
    idle_cycles = 0; prev_g = '0;
    for (int c = 0; c < 45; c++) begin
      cyc(5'h1F, 5'h1F, 1'b1, "rr_all", got);
      if (got[20:16] != 5'b0 && got[20:16] != prev_g)
        for (int b = 0; b < 5; b++) if (got[16 + b]) order.push_back(b);
      if (c >= 1 && !got[2]) idle_cycles++;
      prev_g = got[20:16];
    end
    chk_v("rr_grant_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      chk_v($sformatf("rr_order[%0d]", i), (i < order.size()) ? order[i] : -1, i % 5);
    chk_v("rr_idle_cycles", idle_cycles, 0);

    // Asynchronous reset mid-packet.
    request = 5'h1F; flit_valid = 5'h1F; credit_return = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("reset_mid_send", dut_bundle(), {5'b0, 3'd5, 5'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0});
    model_reset();
    @(negedge clk);
    reset = 1'b1;

`ifdef NOC_OSCHED_WATCHDOG_EN
    cyc(5'b00001, 5'h00, 1'b0, "wd_load", got);
    for (int i = 1; i <= STALL; i++) begin
      cyc(5'b0, 5'h00, 1'b0, "wd_stall", got);
      if (i == STALL - 1) chk_v("stall_err_early", int'(stall_err), 0);
    end
    chk_v("stall_err_set", int'(stall_err), 1);
    chk_v("stall_grant_held", int'(grant_vec), 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rq, fv; logic cr;
      rq = 5'($urandom) & 5'($urandom) & 5'($urandom);
      fv = 5'($urandom) | 5'($urandom);
      cr = (m_cred < CMAX) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      cyc(rq, fv, cr, "random", got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
